// File: rtl/key_evt_pkg.sv
// rtl/key_evt_pkg.sv - shared state type and default timing constants for the key event classifier
package key_evt_pkg;

  // Classifier FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HOLD   = 3'd4
  } key_state_e;

  // Defaults for a 12 MHz system clock
  localparam int unsigned LONG_CYC_DEF = 12_000_000;  // 1 s long-press threshold
  localparam int unsigned DBL_CYC_DEF  = 3_000_000;   // 250 ms double-press window
  localparam int unsigned RPT_CYC_DEF  = 2_400_000;   // 200 ms auto-repeat period

  // Largest of the three timing constants, used to size the shared counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_timer.sv
// rtl/key_timer.sv - saturating cycle counter with sync clear and terminal compare
module key_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [CW-1:0] term,
  output logic [CW-1:0] cnt,
  output logic          done
);

  // Terminal count reached for the currently selected interval
  assign done = (cnt == term);

  // Count up, clear on request, and hold at the terminal value so the count never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_classifier.sv
// rtl/key_event_classifier.sv - classifies debounced key presses into short/double/long/repeat pulses
module key_event_classifier
  import key_evt_pkg::*;
#(
  parameter logic        PRESS_LEVEL = 1'b0,
  parameter int unsigned LONG_CYC    = LONG_CYC_DEF,
  parameter int unsigned DBL_CYC     = DBL_CYC_DEF,
  parameter int unsigned RPT_CYC     = RPT_CYC_DEF
) (
  input  logic Sys_clk,
  input  logic Sys_reset,
  input  logic Key_in,
  output logic Short_pulse,
  output logic Double_pulse,
  output logic Long_pulse,
  output logic Repeat_pulse,
  output logic Hold_level
);

  localparam int unsigned CW = $clog2(max3(LONG_CYC, DBL_CYC, RPT_CYC)) + 1;

  localparam logic [CW-1:0] LONG_TERM = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] DBL_TERM  = CW'(DBL_CYC - 1);
  localparam logic [CW-1:0] RPT_TERM  = CW'(RPT_CYC - 1);

  key_state_e    state;
  logic          p_q;       // registered "key is pressed"
  logic          sampled;   // p_q holds a real sample of Key_in (not just its reset value)
  logic          armed;     // a released key has been seen since reset
  logic          tmr_clr;
  logic [CW-1:0] tmr_term;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_done;

  key_timer #(
    .CW(CW)
  ) u_timer (
    .clk  (Sys_clk),
    .rst_n(Sys_reset),
    .clr  (tmr_clr),
    .term (tmr_term),
    .cnt  (tmr_cnt),
    .done (tmr_done)
  );

  // Select the interval being timed; untimed states saturate at all-ones
  always_comb begin
    tmr_term = '1;
    case (state)
      PRESS1:  tmr_term = LONG_TERM;
      WAIT2:   tmr_term = DBL_TERM;
      HOLD:    tmr_term = RPT_TERM;
      default: tmr_term = '1;
    endcase
  end

  // Clear the timer on every state change and on each auto-repeat
  always_comb begin
    tmr_clr = 1'b0;
    case (state)
      IDLE:    tmr_clr = p_q && armed;
      PRESS1:  tmr_clr = !p_q || tmr_done;
      WAIT2:   tmr_clr = p_q || tmr_done;
      PRESS2:  tmr_clr = !p_q;
      HOLD:    tmr_clr = !p_q || tmr_done;
      default: tmr_clr = 1'b1;
    endcase
  end

  // Input register, arming, classifier FSM and registered event outputs
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      state        <= IDLE;
      p_q          <= 1'b0;
      sampled      <= 1'b0;
      armed        <= 1'b0;
      Short_pulse  <= 1'b0;
      Double_pulse <= 1'b0;
      Long_pulse   <= 1'b0;
      Repeat_pulse <= 1'b0;
      Hold_level   <= 1'b0;
    end else begin
      p_q          <= (Key_in == PRESS_LEVEL);
      sampled      <= 1'b1;
      Short_pulse  <= 1'b0;
      Double_pulse <= 1'b0;
      Long_pulse   <= 1'b0;
      Repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          Hold_level <= 1'b0;
          // A key held through reset must be released before it can start a press
          if (!p_q && sampled) begin
            armed <= 1'b1;
          end
          if (p_q && armed) begin
            state <= PRESS1;
          end
        end
        PRESS1: begin
          if (!p_q) begin
            state <= WAIT2;
          end else if (tmr_done) begin
            state      <= HOLD;
            Long_pulse <= 1'b1;
            Hold_level <= 1'b1;
          end
        end
        WAIT2: begin
          if (p_q) begin
            state <= PRESS2;
          end else if (tmr_done) begin
            state       <= IDLE;
            Short_pulse <= 1'b1;
          end
        end
        PRESS2: begin
          if (!p_q) begin
            state        <= IDLE;
            Double_pulse <= 1'b1;
          end
        end
        HOLD: begin
          // Release wins over a repeat falling due on the same edge
          if (!p_q) begin
            state      <= IDLE;
            Hold_level <= 1'b0;
          end else if (tmr_done) begin
            Repeat_pulse <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          Hold_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_classifier.sv
// tb/tb_key_event_classifier.sv - directed self-checking bench for key_event_classifier
module tb_key_event_classifier;

  localparam int LONG_CYC = 20;
  localparam int DBL_CYC  = 8;
  localparam int RPT_CYC  = 5;

  logic Sys_clk   = 1'b0;
  logic Sys_reset = 1'b0;
  logic Key_in    = 1'b1;
  logic Short_pulse;
  logic Double_pulse;
  logic Long_pulse;
  logic Repeat_pulse;
  logic Hold_level;

  key_event_classifier #(
    .PRESS_LEVEL(1'b0),
    .LONG_CYC   (LONG_CYC),
    .DBL_CYC    (DBL_CYC),
    .RPT_CYC    (RPT_CYC)
  ) dut (
    .Sys_clk     (Sys_clk),
    .Sys_reset   (Sys_reset),
    .Key_in      (Key_in),
    .Short_pulse (Short_pulse),
    .Double_pulse(Double_pulse),
    .Long_pulse  (Long_pulse),
    .Repeat_pulse(Repeat_pulse),
    .Hold_level  (Hold_level)
  );

  always #5 Sys_clk = ~Sys_clk;

  int edge_n    = 0;
  int short_cnt = 0, dbl_cnt = 0, long_cnt = 0, rpt_cnt = 0, multi_cnt = 0;
  int short_at  = -1, dbl_at = -1, long_at = -1, rpt_at = -1;
  int n_checks  = 0;
  int n_fails   = 0;
  int s_short, s_dbl, s_long, s_rpt;
  int e0, r;

  // Number every rising edge
  always @(posedge Sys_clk) edge_n <= edge_n + 1;

  // Log each pulse with the edge that raised it
  always @(negedge Sys_clk) begin
    if (Short_pulse)  begin short_cnt <= short_cnt + 1; short_at <= edge_n; end
    if (Double_pulse) begin dbl_cnt   <= dbl_cnt + 1;   dbl_at   <= edge_n; end
    if (Long_pulse)   begin long_cnt  <= long_cnt + 1;  long_at  <= edge_n; end
    if (Repeat_pulse) begin rpt_cnt   <= rpt_cnt + 1;   rpt_at   <= edge_n; end
    if ((int'(Short_pulse) + int'(Double_pulse) + int'(Long_pulse) + int'(Repeat_pulse)) > 1)
      multi_cnt <= multi_cnt + 1;
  end

  function automatic int outs();
    return int'({Short_pulse, Double_pulse, Long_pulse, Repeat_pulse, Hold_level});
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Sys_clk);
    #1;
  endtask

  task automatic press(input int n);
    Key_in = 1'b0;
    step(n);
    Key_in = 1'b1;
  endtask

  task automatic mark();
    s_short = short_cnt;
    s_dbl   = dbl_cnt;
    s_long  = long_cnt;
    s_rpt   = rpt_cnt;
  endtask

  task automatic check_counts(input string tag, input int es, input int ed, input int el,
                              input int er);
    check({tag, "_short"},  short_cnt - s_short, es);
    check({tag, "_double"}, dbl_cnt - s_dbl,     ed);
    check({tag, "_long"},   long_cnt - s_long,   el);
    check({tag, "_repeat"}, rpt_cnt - s_rpt,     er);
  endtask

  initial begin
    // Reset state
    step(3);
    check("reset_outputs", outs(), 0);
    Sys_reset = 1'b1;
    step(5);
    check("idle_outputs", outs(), 0);

    // 1: short press of 5 cycles
    mark();
    e0 = edge_n + 1;
    press(5);
    r = e0 + 5;
    step(20);
    check_counts("t1", 1, 0, 0, 0);
    check("t1_short_edge", short_at, r + 9);

    // 2a: re-press sampled at r+8 -> double
    mark();
    e0 = edge_n + 1;
    press(5);
    r = e0 + 5;
    step(8);
    press(3);
    step(15);
    check_counts("t2a", 0, 1, 0, 0);
    check("t2a_double_edge", dbl_at, r + 12);

    // 2b: re-press sampled at r+9 -> short, then a fresh sequence
    mark();
    e0 = edge_n + 1;
    press(5);
    r = e0 + 5;
    step(9);
    press(3);
    step(1);
    check("t2b_first_short_count", short_cnt - s_short, 1);
    check("t2b_first_short_edge", short_at, r + 9);
    step(20);
    check_counts("t2b", 2, 0, 0, 0);
    check("t2b_second_short_edge", short_at, r + 21);

    // 3: hold for 35 cycles -> long, two repeats, release beats coincident repeat
    mark();
    e0 = edge_n + 1;
    Key_in = 1'b0;
    step(25);
    check("t3_hold_level_on", int'(Hold_level), 1);
    check("t3_long_edge", long_at, e0 + 21);
    step(10);
    Key_in = 1'b1;
    step(1);
    check("t3_hold_level_at_release", int'(Hold_level), 1);
    step(1);
    check("t3_hold_level_off", int'(Hold_level), 0);
    step(10);
    check_counts("t3", 0, 0, 1, 2);
    check("t3_last_repeat_edge", rpt_at, e0 + 31);

    // 4a: exactly LONG_CYC pressed samples -> short path
    mark();
    e0 = edge_n + 1;
    press(20);
    r = e0 + 20;
    step(20);
    check_counts("t4_20", 1, 0, 0, 0);
    check("t4_20_short_edge", short_at, r + 9);

    // 4b: LONG_CYC+1 pressed samples -> long
    mark();
    e0 = edge_n + 1;
    press(21);
    step(10);
    check_counts("t4_21", 0, 0, 1, 0);
    check("t4_21_long_edge", long_at, e0 + 21);

    // 4c: release coincides with first repeat -> no repeat
    mark();
    press(25);
    step(10);
    check_counts("t4_25", 0, 0, 1, 0);

    // 4d: one edge longer -> exactly one repeat
    mark();
    e0 = edge_n + 1;
    press(26);
    step(10);
    check_counts("t4_26", 0, 0, 1, 1);
    check("t4_26_repeat_edge", rpt_at, e0 + 26);

    // 5: key held across reset release -> ignored until released
    Sys_reset = 1'b0;
    Key_in    = 1'b0;
    step(3);
    Sys_reset = 1'b1;
    mark();
    step(50);
    check_counts("t5_held", 0, 0, 0, 0);
    check("t5_held_outputs", outs(), 0);
    Key_in = 1'b1;
    step(5);
    mark();
    e0 = edge_n + 1;
    press(3);
    r = e0 + 3;
    step(15);
    check_counts("t5_after", 1, 0, 0, 0);
    check("t5_short_edge", short_at, r + 9);

    // 6a: reset during WAIT2 discards the pending short
    mark();
    press(5);
    step(4);
    Sys_reset = 1'b0;
    #2;
    check("t6_wait2_async_outputs", outs(), 0);
    step(2);
    Sys_reset = 1'b1;
    step(20);
    check_counts("t6_wait2", 0, 0, 0, 0);

    // 6b: reset during HOLD clears outputs at once and stops repeats
    mark();
    Key_in = 1'b0;
    step(30);
    check("t6_hold_before_reset", int'(Hold_level), 1);
    Sys_reset = 1'b0;
    #2;
    check("t6_hold_async_outputs", outs(), 0);
    step(2);
    Sys_reset = 1'b1;
    step(20);
    check_counts("t6_hold", 0, 0, 1, 1);
    Key_in = 1'b1;
    step(5);
    check("t6_hold_level_after", int'(Hold_level), 0);

    check("one_hot_events", multi_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
